reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter XLEN, 32, data width of each register.
REQ-002 Parameter NREG, 32, number of architectural registers; index width 5.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 nReset  input  1  reset, asynchronous, active-low.
REQ-005 Wreg  input  1  write-back write enable.
REQ-006 rd  input  5  write-back destination index.
REQ-007 Wdata  input  XLEN  write-back data.
REQ-008 rs1, rs2  input  5 each  read-port indices of the issuing instruction.
REQ-009 use_rs1, use_rs2  input  1 each  issuing instruction reads rs1 / rs2.
REQ-010 issue_valid  input  1  an instruction requests issue this cycle.
REQ-011 issue_wreg  input  1  issuing instruction will write a register.
REQ-012 issue_rd  input  5  destination index of the issuing instruction.
REQ-013 flush  input  1  discard all pending-write tracking.
REQ-014 rdata1, rdata2  output  XLEN each  read data for rs1 / rs2.
REQ-015 stall  output  1  issue blocked this cycle.
REQ-016 pending_any  output  1  at least one pending counter is non-zero.

Function
REQ-017 Register array: NREG x XLEN; at posedge, when Wreg=1 and rd!=0, the block SHALL write regs[rd] <= Wdata.
REQ-018 Index 0 SHALL read as 0 at all times; writes to index 0 are ignored.
REQ-019 Read ports SHALL be combinational, 0-cycle latency: rdataN = 0 if rsN=0; else Wdata if Wreg=1 and rd=rsN (write-through bypass); else regs[rsN].
REQ-020 Scoreboard: per register r (1..NREG-1), 2-bit pending counter pend[r]; pend[0] is constant 0.
REQ-021 issue_fire = issue_valid & ~stall & issue_wreg & (issue_rd!=0); retire = Wreg & (rd!=0).
REQ-022 At posedge, for each r: issue_fire to r without retire of r -> pend[r]+1; retire of r without issue_fire -> pend[r]-1, saturating at 0; both to the same r -> no change; neither -> no change.
REQ-023 flush=1 at posedge SHALL clear all pend[] to 0, overriding REQ-022; a retire arriving later to a register with pend=0 SHALL leave it at 0.
REQ-024 Hazard on source N: use_rsN & (rsN!=0) & (pend[rsN]!=0) & ~(retire & rd=rsN & pend[rsN]=1).
REQ-025 stall SHALL be combinational: issue_valid & (hazard rs1 | hazard rs2 | (issue_wreg & issue_rd!=0 & pend[issue_rd]=3)).
REQ-026 stall SHALL be 0 whenever issue_valid=0 or flush=1.
REQ-027 With flush=1, issue_fire in the same cycle SHALL NOT increment any counter.
REQ-028 pending_any SHALL be the OR of all pend[r]!=0, from registered state only.
REQ-029 A counter at 3 SHALL never increment; REQ-025 guarantees this, and an assertion SHALL check it.

Reset
REQ-030 On nReset=0, asynchronously: all regs[] = 0 and all pend[] = 0; hence rdata1=rdata2=0 for every index, stall=0 unless a source/dest hazard exists (none at reset), pending_any=0.
REQ-031 Reset asserted mid-operation SHALL discard all writes and pending state; the first posedge after deassertion behaves as a post-reset cycle.

Verification
REQ-032 Write/read: Wreg=1, rd=5, Wdata=0xDEADBEEF, then rs1=5 next cycle -> rdata1=0xDEADBEEF; same-cycle rs2=5 -> rdata2=0xDEADBEEF via bypass.
REQ-033 x0: Wreg=1, rd=0, Wdata=0x1234 -> rdata1 with rs1=0 reads 0, pend unchanged, pending_any=0.
REQ-034 RAW stall: issue rd=7 (fires), next cycle issue use_rs1=1, rs1=7 -> stall=1 until the cycle Wreg=1, rd=7, where stall=0 and rdata1=Wdata.
REQ-035 Saturation: three issues to rd=9 with no retire -> pend[9]=3; fourth issue_wreg to rd=9 -> stall=1; one retire rd=9 -> pend=2, issue accepted.
REQ-036 Simultaneous: pend[3]=1, same cycle issue_fire rd=3 and retire rd=3 -> pend[3] stays 1.
REQ-037 Flush/reset: pend[4]=2, flush=1 -> pending_any=0 next cycle, later retire rd=4 keeps pend[4]=0; nReset pulse mid-stream -> all reads 0.

Source files
------------

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - bundled write-back, read and issue signals for reg_file
//
// Purpose: groups every non-clock/reset signal of reg_file so the pipeline
//   and the register file share one connection.
// Signals:
//   Wreg, rd, Wdata         write-back port (enable, index, data)
//   rs1, rs2                source indices of the issuing instruction
//   use_rs1, use_rs2        issuing instruction actually reads rs1 / rs2
//   issue_valid             an instruction requests issue this cycle
//   issue_wreg, issue_rd    issuing instruction writes register issue_rd
//   flush                   drop all pending-write tracking
//   rdata1, rdata2          read data for rs1 / rs2 (combinational)
//   stall                   issue blocked this cycle
//   pending_any             some register still has an outstanding write
// Modports: master drives requests (pipeline side), slave is reg_file.
interface reg_file_if #(parameter int XLEN = 32);
  logic            Wreg;
  logic [4:0]      rd;
  logic [XLEN-1:0] Wdata;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            use_rs1;
  logic            use_rs2;
  logic            issue_valid;
  logic            issue_wreg;
  logic [4:0]      issue_rd;
  logic            flush;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            stall;
  logic            pending_any;

  modport master (
    output Wreg, rd, Wdata, rs1, rs2, use_rs1, use_rs2,
           issue_valid, issue_wreg, issue_rd, flush,
    input  rdata1, rdata2, stall, pending_any
  );

  modport slave (
    input  Wreg, rd, Wdata, rs1, rs2, use_rs1, use_rs2,
           issue_valid, issue_wreg, issue_rd, flush,
    output rdata1, rdata2, stall, pending_any
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file with write-through bypass and pending-write scoreboard
//
// Purpose: NREG x XLEN architectural registers (index 0 hard-wired to zero),
//   two combinational read ports that bypass the same-cycle write-back, and
//   a 2-bit per-register count of in-flight writes used to stall issue on
//   read-after-write hazards and on counter saturation.
// Ports:
//   Clock   rising-edge clock for all state
//   nReset  asynchronous active-low reset (clears registers and counters)
//   bus     reg_file_if.slave: write-back, read, issue and flush signals
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic        Clock,
  input logic        nReset,
  reg_file_if.slave  bus
);

  logic [XLEN-1:0] regs [NREG];
  logic [1:0]      pend [NREG];

  logic       retire;
  logic       issue_fire;
  logic [1:0] pend_rs1;
  logic [1:0] pend_rs2;
  logic [1:0] pend_rd;
  logic       hazard1;
  logic       hazard2;
  logic       dest_full;
  logic       any;

  assign retire   = bus.Wreg && (bus.rd != 5'd0);
  assign pend_rs1 = pend[bus.rs1];
  assign pend_rs2 = pend[bus.rs2];
  assign pend_rd  = pend[bus.issue_rd];

  // Read ports: a write-back in flight this cycle is forwarded directly.
  always_comb begin
    bus.rdata1 = '0;
    if (bus.rs1 != 5'd0)
      bus.rdata1 = (retire && bus.rd == bus.rs1) ? bus.Wdata : regs[bus.rs1];
  end

  always_comb begin
    bus.rdata2 = '0;
    if (bus.rs2 != 5'd0)
      bus.rdata2 = (retire && bus.rd == bus.rs2) ? bus.Wdata : regs[bus.rs2];
  end

  // The last outstanding write retiring this cycle is already visible via
  // the bypass, so it does not block the reader.
  assign hazard1 = bus.use_rs1 && (bus.rs1 != 5'd0) && (pend_rs1 != 2'd0) &&
                   !(retire && bus.rd == bus.rs1 && pend_rs1 == 2'd1);
  assign hazard2 = bus.use_rs2 && (bus.rs2 != 5'd0) && (pend_rs2 != 2'd0) &&
                   !(retire && bus.rd == bus.rs2 && pend_rs2 == 2'd1);

  // A saturated counter cannot take another outstanding write.
  assign dest_full = bus.issue_wreg && (bus.issue_rd != 5'd0) && (pend_rd == 2'd3);

  assign bus.stall  = bus.issue_valid && !bus.flush && (hazard1 || hazard2 || dest_full);
  assign issue_fire = bus.issue_valid && !bus.stall && bus.issue_wreg &&
                      (bus.issue_rd != 5'd0);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= 2'd0;
      end
    end else begin
      if (retire)
        regs[bus.rd] <= bus.Wdata;
      // pend[0] is never touched here and so stays at its reset value of 0.
      for (int r = 1; r < NREG; r++) begin
        if (bus.flush)
          pend[r] <= 2'd0;
        else if (issue_fire && bus.issue_rd == 5'(r) && !(retire && bus.rd == 5'(r)))
          pend[r] <= pend[r] + 2'd1;
        else if (retire && bus.rd == 5'(r) && !(issue_fire && bus.issue_rd == 5'(r)) &&
                 pend[r] != 2'd0)
          pend[r] <= pend[r] - 2'd1;
      end
    end
  end

  always_comb begin
    any = 1'b0;
    for (int r = 1; r < NREG; r++)
      any = any | (pend[r] != 2'd0);
  end
  assign bus.pending_any = any;

  // Saturation is prevented by dest_full; this guards that reasoning.
  pend_no_overflow: assert property (@(posedge Clock) disable iff (!nReset)
    !(issue_fire && !bus.flush && !(retire && bus.rd == bus.issue_rd) && pend_rd == 2'd3));

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - table-driven self-checking bench for reg_file
module tb_reg_file;

  logic Clock;
  logic nReset;

  reg_file_if #(.XLEN(32)) bus ();

  reg_file #(.XLEN(32), .NREG(32)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        iv;
    logic        iw;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic        e_stall;
    logic        e_pany;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic wreg, input logic [4:0] rd, input logic [31:0] wdata,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic iv, input logic iw,
                     input logic [4:0] ird, input logic fl,
                     input logic [31:0] e_r1, input logic [31:0] e_r2,
                     input logic e_stall, input logic e_pany);
    vec_t v;
    v = '{wreg, rd, wdata, rs1, rs2, u1, u2, iv, iw, ird, fl, e_r1, e_r2, e_stall, e_pany};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.Wreg        = v.wreg;
    bus.rd          = v.rd;
    bus.Wdata       = v.wdata;
    bus.rs1         = v.rs1;
    bus.rs2         = v.rs2;
    bus.use_rs1     = v.u1;
    bus.use_rs2     = v.u2;
    bus.issue_valid = v.iv;
    bus.issue_wreg  = v.iw;
    bus.issue_rd    = v.ird;
    bus.flush       = v.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " rdata1"}, bus.rdata1, v.e_r1);
    chk({tag, " rdata2"}, bus.rdata2, v.e_r2);
    chk({tag, " stall"}, {31'd0, bus.stall}, {31'd0, v.e_stall});
    chk({tag, " pending_any"}, {31'd0, bus.pending_any}, {31'd0, v.e_pany});
  endtask

  vec_t idle;
  vec_t v;

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle  = '0;

    //  wreg rd  wdata          rs1 rs2 u1 u2 iv iw ird fl  e_r1           e_r2           st pa
    add(0,  0,  32'h0,         5,  31, 0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 0); // 0 idle after reset
    add(1,  5,  32'hDEADBEEF,  0,  5,  0, 0, 0, 0, 0,  0,  32'h0,         32'hDEADBEEF,  0, 0); // 1 write 5, bypass rs2
    add(0,  0,  32'h0,         5,  0,  0, 0, 0, 0, 0,  0,  32'hDEADBEEF,  32'h0,         0, 0); // 2 read 5 from array
    add(1,  0,  32'h1234,      0,  0,  0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 0); // 3 write x0
    add(0,  0,  32'h0,         0,  5,  0, 0, 0, 0, 0,  0,  32'h0,         32'hDEADBEEF,  0, 0); // 4 x0 still 0, no pend
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 7,  0,  32'h0,         32'h0,         0, 0); // 5 issue rd=7
    add(0,  0,  32'h0,         7,  0,  1, 0, 1, 0, 0,  0,  32'h0,         32'h0,         1, 1); // 6 RAW stall
    add(0,  0,  32'h0,         7,  0,  1, 0, 1, 0, 0,  0,  32'h0,         32'h0,         1, 1); // 7 RAW stall held
    add(1,  7,  32'h777,       7,  0,  1, 0, 1, 0, 0,  0,  32'h777,       32'h0,         0, 1); // 8 retire 7 releases
    add(0,  0,  32'h0,         7,  0,  0, 0, 0, 0, 0,  0,  32'h777,       32'h0,         0, 0); // 9 drained
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 9,  0,  32'h0,         32'h0,         0, 0); // 10 issue 9 (1)
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 9,  0,  32'h0,         32'h0,         0, 1); // 11 issue 9 (2)
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 9,  0,  32'h0,         32'h0,         0, 1); // 12 issue 9 (3)
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 9,  0,  32'h0,         32'h0,         1, 1); // 13 saturated
    add(1,  9,  32'h99,        0,  0,  0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 1); // 14 retire 9 -> 2
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 9,  0,  32'h0,         32'h0,         0, 1); // 15 issue accepted -> 3
    add(1,  9,  32'h99,        9,  0,  1, 0, 1, 0, 0,  0,  32'h99,        32'h0,         1, 1); // 16 retire at 3 still hazard
    add(1,  9,  32'h99,        9,  0,  1, 0, 1, 0, 0,  0,  32'h99,        32'h0,         1, 1); // 17 retire at 2 still hazard
    add(1,  9,  32'h99,        9,  0,  1, 0, 1, 0, 0,  0,  32'h99,        32'h0,         0, 1); // 18 last retire bypasses
    add(0,  0,  32'h0,         9,  0,  0, 0, 0, 0, 0,  0,  32'h99,        32'h0,         0, 0); // 19 drained
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 3,  0,  32'h0,         32'h0,         0, 0); // 20 issue 3
    add(1,  3,  32'h33,        0,  0,  0, 0, 1, 1, 3,  0,  32'h0,         32'h0,         0, 1); // 21 issue+retire 3
    add(0,  0,  32'h0,         3,  0,  1, 0, 1, 0, 0,  0,  32'h33,        32'h0,         1, 1); // 22 pend3 still 1
    add(1,  3,  32'h34,        0,  0,  0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 1); // 23 retire 3
    add(0,  0,  32'h0,         3,  0,  0, 0, 0, 0, 0,  0,  32'h34,        32'h0,         0, 0); // 24 drained
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 4,  0,  32'h0,         32'h0,         0, 0); // 25 issue 4
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 4,  0,  32'h0,         32'h0,         0, 1); // 26 issue 4 -> 2
    add(0,  0,  32'h0,         4,  0,  1, 0, 1, 1, 4,  1,  32'h0,         32'h0,         0, 1); // 27 flush masks stall
    add(0,  0,  32'h0,         0,  0,  0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 0); // 28 flushed
    add(1,  4,  32'h44,        0,  0,  0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 0); // 29 late retire 4
    add(0,  0,  32'h0,         4,  0,  1, 0, 1, 0, 0,  0,  32'h44,        32'h0,         0, 0); // 30 pend4 stayed 0
    add(0,  0,  32'h0,         0,  0,  0, 0, 1, 1, 12, 0,  32'h0,         32'h0,         0, 0); // 31 issue 12
    add(0,  0,  32'h0,         12, 12, 0, 0, 1, 0, 0,  0,  32'h0,         32'h0,         0, 1); // 32 unused sources
    add(0,  0,  32'h0,         12, 12, 0, 1, 1, 0, 0,  0,  32'h0,         32'h0,         1, 1); // 33 rs2 hazard
    add(1,  12, 32'hC,         0,  0,  0, 0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 1); // 34 retire 12
    add(0,  0,  32'h0,         0,  12, 0, 0, 0, 0, 0,  0,  32'h0,         32'hC,         0, 0); // 35 drained

    // Reset state, checked before any clock edge.
    nReset = 1'b0;
    v = idle;
    v.rs1 = 5'd5;
    v.rs2 = 5'd31;
    drive(v);
    #1;
    check_vec("reset", v);
    @(negedge Clock);
    nReset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge Clock);
      drive(vecs[i]);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset pulse mid-stream with a write outstanding on x10.
    @(negedge Clock);
    v = idle; v.iv = 1'b1; v.iw = 1'b1; v.ird = 5'd10;
    drive(v);
    @(negedge Clock);
    drive(idle);
    #1;
    chk("pre_reset pending_any", {31'd0, bus.pending_any}, 32'd1);
    #1;
    nReset = 1'b0;
    v = idle; v.rs1 = 5'd5; v.rs2 = 5'd7;
    drive(v);
    #1;
    chk("in_reset pending_any", {31'd0, bus.pending_any}, 32'd0);
    chk("in_reset rdata1", bus.rdata1, 32'h0);
    chk("in_reset rdata2", bus.rdata2, 32'h0);
    @(negedge Clock);
    nReset = 1'b1;
    v = idle; v.rs1 = 5'd9; v.rs2 = 5'd3;
    drive(v);
    #1;
    chk("post_reset rdata1", bus.rdata1, 32'h0);
    chk("post_reset rdata2", bus.rdata2, 32'h0);
    chk("post_reset pending_any", {31'd0, bus.pending_any}, 32'd0);
    @(negedge Clock);
    v = idle; v.iv = 1'b1; v.iw = 1'b1; v.ird = 5'd10; v.rs1 = 5'd10;
    drive(v);
    #1;
    chk("post_reset issue stall", {31'd0, bus.stall}, 32'd0);
    @(negedge Clock);
    v = idle; v.iv = 1'b1; v.u1 = 1'b1; v.rs1 = 5'd10;
    drive(v);
    #1;
    chk("post_reset pend10 pending_any", {31'd0, bus.pending_any}, 32'd1);
    chk("post_reset pend10 stall", {31'd0, bus.stall}, 32'd1);
    chk("post_reset x10 cleared", bus.rdata1, 32'h0);

    @(negedge Clock);
    drive(idle);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
